// File: rtl/bitstream_packer.sv
// Packs a serial bit stream LSB-first into bytes and buffers them in a show-ahead
// byte FIFO drained by a valid/ready handshake. Flush pads and emits a partial byte.
module bitstream_packer #(
  parameter int   FIFO_DEPTH = 4,
  parameter logic PAD_BIT    = 1'b0
) (
  input  logic                          CLK_8,
  input  logic                          Reset,
  input  logic                          SB,
  input  logic                          SV,
  input  logic                          Flush,
  input  logic                          Byte_Ready,
  output logic [7:0]                    Byte_Out,
  output logic                          Byte_Valid,
  output logic [2:0]                    Bit_Count,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
  output logic                          Overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  logic [7:0]    r_acc;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  logic [3:0]    w_cnt_incl;
  logic [7:0]    w_acc_bit;
  logic [7:0]    w_push_byte;
  logic          w_complete;
  logic          w_flush_push;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_write;

  // Count including this edge's bit; reaching 8 means the byte just completed.
  assign w_cnt_incl = {1'b0, r_bit_cnt} + {3'b000, SV};

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_acc_bit = r_acc;
    if (SV) w_acc_bit[r_bit_cnt] = SB;
    w_push_byte = '0;
    for (int i = 0; i < 8; i++)
      w_push_byte[i] = (i < int'(w_cnt_incl)) ? w_acc_bit[i] : PAD_BIT;
  end

  assign w_complete   = w_cnt_incl[3];
  assign w_flush_push = Flush && !w_complete && (w_cnt_incl != 4'd0);
  assign w_push       = w_complete || w_flush_push;
  assign w_pop        = (r_level != '0) && Byte_Ready;
  assign w_full       = (r_level == FULL_LEVEL);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign w_write      = w_push && (!w_full || w_pop);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_8) begin
    if (Reset) begin
      r_acc      <= '0;
      r_bit_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_acc     <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_acc     <= w_acc_bit;
        r_bit_cnt <= w_cnt_incl[2:0];
      end
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_write) r_overflow <= 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy gates visibility, so stale data never escapes.
  always_ff @(posedge CLK_8) begin
    if (w_write && !Reset) r_mem[r_wr_ptr] <= w_push_byte;
  end

  assign Byte_Valid = (r_level != '0);
  assign Byte_Out   = Byte_Valid ? r_mem[r_rd_ptr] : 8'h00;
  assign Bit_Count  = r_bit_cnt;
  assign Fifo_Level = r_level;
  assign Overflow   = r_overflow;

endmodule

// File: tb/tb_bitstream_packer.sv
// Self-checking bench for bitstream_packer: directed scenarios plus random traffic,
// compared against a queue-based byte-stream model for PAD_BIT=0 and PAD_BIT=1 instances.
module tb_bitstream_packer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, sb, sv, flush, ready;
  logic [7:0]    bo0, bo1;
  logic          bv0, bv1, ov0, ov1;
  logic [2:0]    bc0, bc1;
  logic [LW-1:0] fl0, fl1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bitstream_packer #(.FIFO_DEPTH(DEPTH), .PAD_BIT(1'b0)) dut0 (
    .CLK_8(clk), .Reset(rst), .SB(sb), .SV(sv), .Flush(flush), .Byte_Ready(ready),
    .Byte_Out(bo0), .Byte_Valid(bv0), .Bit_Count(bc0), .Fifo_Level(fl0), .Overflow(ov0)
  );

  bitstream_packer #(.FIFO_DEPTH(DEPTH), .PAD_BIT(1'b1)) dut1 (
    .CLK_8(clk), .Reset(rst), .SB(sb), .SV(sv), .Flush(flush), .Byte_Ready(ready),
    .Byte_Out(bo1), .Byte_Valid(bv1), .Bit_Count(bc1), .Fifo_Level(fl1), .Overflow(ov1)
  );

  // Reference: pending bits as a queue, bytes as a queue, sticky drop flag.
  bit       m_bits [2][$];
  bit [7:0] m_fifo [2][$];
  bit       m_ovf  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int p, input bit pad, input bit r, input bit v,
                            input bit b, input bit f, input bit rdy);
    int       pre;
    bit       pop, push;
    bit [7:0] nb;
    if (r) begin
      m_bits[p].delete();
      m_fifo[p].delete();
      m_ovf[p] = 1'b0;
      return;
    end
    pre  = m_fifo[p].size();
    pop  = (pre > 0) && rdy;
    push = 1'b0;
    nb   = 8'h00;
    if (v) m_bits[p].push_back(b);
    if (m_bits[p].size() == 8 || (f && m_bits[p].size() > 0)) begin
      while (m_bits[p].size() < 8) m_bits[p].push_back(pad);
      for (int i = 0; i < 8; i++) nb = nb + (8'(m_bits[p][i]) << i);
      m_bits[p].delete();
      push = 1'b1;
    end
    if (pop) void'(m_fifo[p].pop_front());
    if (push) begin
      if (pre == DEPTH && !pop) m_ovf[p] = 1'b1;
      else m_fifo[p].push_back(nb);
    end
  endtask

  task automatic compare(input int p, input logic [7:0] bo, input logic bv,
                         input logic [2:0] bc, input logic [LW-1:0] fl, input logic ov);
    logic [7:0] exp_bo;
    exp_bo = (m_fifo[p].size() > 0) ? m_fifo[p][0] : 8'h00;
    check($sformatf("p%0d byte_out", p),   bo, exp_bo);
    check($sformatf("p%0d byte_valid", p), bv, (m_fifo[p].size() > 0) ? 1 : 0);
    check($sformatf("p%0d bit_count", p),  bc, m_bits[p].size());
    check($sformatf("p%0d fifo_level", p), fl, m_fifo[p].size());
    check($sformatf("p%0d overflow", p),   ov, m_ovf[p]);
  endtask

  task automatic tick(input bit r, input bit v, input bit b, input bit f, input bit rdy);
    rst = r; sv = v; sb = b; flush = f; ready = rdy;
    @(posedge clk);
    model_step(0, 1'b0, r, v, b, f, rdy);
    model_step(1, 1'b1, r, v, b, f, rdy);
    #1;
    compare(0, bo0, bv0, bc0, fl0, ov0);
    compare(1, bo1, bv1, bc1, fl1, ov1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rdy, input bit flush_last);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, b[i], flush_last && (i == 7), rdy);
  endtask

  initial begin
    logic [7:0] nb;
    rst = 1'b1; sv = 1'b0; sb = 1'b0; flush = 1'b0; ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst valid", bv0, 0);
    check("rst byte", bo0, 8'h00);
    check("rst count", bc0, 0);
    check("rst level", fl0, 0);
    check("rst ovf", ov0, 0);

    // Basic pack: 1,0,1,1,0,0,0,1 -> 0x8D, valid for one cycle
    send_byte(8'h8D, 1'b1, 1'b0);
    check("pack byte", bo0, 8'h8D);
    check("pack valid", bv0, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pack valid drop", bv0, 0);

    // Flush of three ones
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush pad0", bo0, 8'h07);
    check("flush pad1", bo1, 8'hFF);
    check("flush count", bc0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush with nothing pending
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush empty level", fl0, 0);

    // Flush coincident with the 8th bit
    send_byte(8'h3C, 1'b0, 1'b1);
    check("flush8 level", fl0, 1);
    check("flush8 byte", bo0, 8'h3C);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush8 level hold", fl0, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow: five bytes into depth four, then drain
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0, 1'b0);
    check("ovf level", fl0, 4);
    check("ovf flag", ov0, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf drain %0d", k), bo0, 32'(k));
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("ovf drained", bv0, 0);
    check("ovf sticky", ov0, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf cleared", ov0, 0);

    // Full FIFO with push and pop on the same edge
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    nb = 8'h99;
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, nb[i], 1'b0, 1'b0);
    tick(1'b0, 1'b1, nb[7], 1'b0, 1'b1);
    check("fullpp level", fl0, 4);
    check("fullpp ovf", ov0, 0);
    check("fullpp head", bo0, 8'h22);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fullpp tail", bo0, 8'h99);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-byte discards partial bits
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    check("midrst byte", bo0, 8'hA5);
    check("midrst level", fl0, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst empty", bv0, 0);

    // Random traffic, alternating light and heavy back-pressure windows
    for (int k = 0; k < 3000; k++) begin
      bit rdy;
      rdy = ((k / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 15) == 0, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
